// File: rtl/relu_quant_param_pkg.sv
// Shared encodings and default widths for the relu_quant_param output stage.
package relu_quant_param_pkg;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLAMP = 2'd3
    } act_mode_e;

    localparam int unsigned DEF_ACCUM_DATA_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH           = 16;
    localparam int unsigned DEF_COUNT_SLOAD_BITWIDTH = 8;

endpackage

// File: rtl/relu_quant_lane.sv
// One channel: round/shift into stage 1, then saturate and activate into stage 2.
module relu_quant_lane
    import relu_quant_param_pkg::*;
#(
    parameter int unsigned AccW      = 32,
    parameter int unsigned DataW     = 16,
    parameter int unsigned ShiftW    = 5,
    parameter int unsigned LeakShift = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [AccW-1:0]   acc_i,
    input  logic [ShiftW-1:0] shift_amt_i,
    input  logic              round_en_i,
    input  act_mode_e         act_mode_i,
    input  logic [DataW-1:0]  clamp_cap_i,
    output logic [DataW-1:0]  res_o,
    output logic              clip_o
);

    localparam int unsigned SumW = AccW + 1;
    localparam logic signed [SumW-1:0] MaxV = {{(SumW-DataW+1){1'b0}}, {(DataW-1){1'b1}}};
    localparam logic signed [SumW-1:0] MinV = {{(SumW-DataW+1){1'b1}}, {(DataW-1){1'b0}}};

    logic signed [SumW-1:0]  bias;
    logic signed [SumW-1:0]  sum;
    logic signed [SumW-1:0]  s1_d, s1_q;
    logic signed [DataW-1:0] sat_val;
    logic signed [DataW-1:0] act_d;
    logic        [DataW-1:0] res_q;

    always_comb begin
        bias = '0;
        if (round_en_i && (shift_amt_i != '0)) begin
            bias = SumW'(1) << (shift_amt_i - ShiftW'(1));
        end
        sum  = $signed({acc_i[AccW-1], acc_i}) + bias;
        s1_d = sum >>> shift_amt_i;
    end

    always_comb begin
        clip_o  = 1'b0;
        sat_val = s1_q[DataW-1:0];
        if (s1_q > MaxV) begin
            clip_o  = 1'b1;
            sat_val = MaxV[DataW-1:0];
        end else if (s1_q < MinV) begin
            clip_o  = 1'b1;
            sat_val = MinV[DataW-1:0];
        end
    end

    always_comb begin
        act_d = sat_val;
        unique case (act_mode_i)
            ACT_NONE:  act_d = sat_val;
            ACT_RELU:  if (sat_val[DataW-1]) act_d = '0;
            ACT_LEAKY: if (sat_val[DataW-1]) act_d = sat_val >>> LeakShift;
            ACT_CLAMP: begin
                // The cap is an unsigned bound, so a set MSB can never clamp.
                if (sat_val[DataW-1]) begin
                    act_d = '0;
                end else if ($unsigned(sat_val) > clamp_cap_i) begin
                    act_d = clamp_cap_i;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q  <= '0;
            res_q <= '0;
        end else begin
            if (load_i) s1_q <= s1_d;
            if (adv_i)  res_q <= act_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/relu_quant_param.sv
// Multi-channel rescale/saturate/activation stage: capture control, valid pipe, sticky flags.
module relu_quant_param
    import relu_quant_param_pkg::*;
#(
    parameter int unsigned NUM_CH               = 4,
    parameter int unsigned ACCUM_DATA_WIDTH     = DEF_ACCUM_DATA_WIDTH,
    parameter int unsigned DATA_WIDTH           = DEF_DATA_WIDTH,
    parameter int unsigned COUNT_SLOAD_BITWIDTH = DEF_COUNT_SLOAD_BITWIDTH,
    parameter int unsigned SLOAD_TAP            = 2,
    parameter int unsigned SHIFT_BITWIDTH       = 5,
    parameter int unsigned LEAK_SHIFT           = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [COUNT_SLOAD_BITWIDTH-1:0]  count_sload,
    input  logic [NUM_CH*ACCUM_DATA_WIDTH-1:0] result,
    input  logic [SHIFT_BITWIDTH-1:0]        shift_amt,
    input  logic                             round_en,
    input  logic [1:0]                       act_mode,
    input  logic [DATA_WIDTH-1:0]            clamp_cap,
    input  logic                             sat_clear,
    output logic [NUM_CH*DATA_WIDTH-1:0]     result_relu,
    output logic                             out_valid,
    output logic [NUM_CH-1:0]                sat_flag
);

    logic                  in_fire;
    logic                  adv;
    logic                  v1_q;
    logic                  out_valid_q;
    act_mode_e             mode_q;
    logic [DATA_WIDTH-1:0] cap_q;
    logic [NUM_CH-1:0]     clip;
    logic [NUM_CH-1:0]     sat_d, sat_q;

    assign in_fire = enable && (count_sload == COUNT_SLOAD_BITWIDTH'(SLOAD_TAP));
    assign adv     = enable && v1_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        relu_quant_lane #(
            .AccW      (ACCUM_DATA_WIDTH),
            .DataW     (DATA_WIDTH),
            .ShiftW    (SHIFT_BITWIDTH),
            .LeakShift (LEAK_SHIFT)
        ) u_lane (
            .clk_i       (clock),
            .rst_ni      (reset),
            .load_i      (in_fire),
            .adv_i       (adv),
            .acc_i       (result[c*ACCUM_DATA_WIDTH +: ACCUM_DATA_WIDTH]),
            .shift_amt_i (shift_amt),
            .round_en_i  (round_en),
            .act_mode_i  (mode_q),
            .clamp_cap_i (cap_q),
            .res_o       (result_relu[c*DATA_WIDTH +: DATA_WIDTH]),
            .clip_o      (clip[c])
        );
    end

    // Set wins over clear; clearing does not depend on enable.
    assign sat_d = (sat_q & ~{NUM_CH{sat_clear}}) | (clip & {NUM_CH{adv}});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            mode_q      <= ACT_NONE;
            cap_q       <= '0;
            sat_q       <= '0;
        end else begin
            if (in_fire) begin
                mode_q <= act_mode_e'(act_mode);
                cap_q  <= clamp_cap;
            end
            if (enable) begin
                v1_q        <= in_fire;
                out_valid_q <= v1_q;
            end
            sat_q <= sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_relu_quant_param.sv
// Randomized scoreboard bench for relu_quant_param against an arithmetic reference model.
module tb_relu_quant_param;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 32;
    localparam int DW     = 16;
    localparam int TAP    = 2;

    logic                    clock;
    logic                    reset;
    logic                    enable;
    logic [7:0]              count_sload;
    logic [NUM_CH*ACC_W-1:0] result;
    logic [4:0]              shift_amt;
    logic                    round_en;
    logic [1:0]              act_mode;
    logic [DW-1:0]           clamp_cap;
    logic                    sat_clear;
    logic [NUM_CH*DW-1:0]    result_relu;
    logic                    out_valid;
    logic [NUM_CH-1:0]       sat_flag;

    relu_quant_param dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .count_sload (count_sload),
        .result      (result),
        .shift_amt   (shift_amt),
        .round_en    (round_en),
        .act_mode    (act_mode),
        .clamp_cap   (clamp_cap),
        .sat_clear   (sat_clear),
        .result_relu (result_relu),
        .out_valid   (out_valid),
        .sat_flag    (sat_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [NUM_CH*DW-1:0] data;
        logic [NUM_CH-1:0]    sat;
        int                   idx;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          drv_cnt  = 0;
    logic [31:0] acc_v [NUM_CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Floor division by 2^sh after optional half-up bias, then clip and activation.
    function automatic void model(input longint acc, input int sh, input bit rnd, input int mode,
                                  input int cap, output int y, output bit sat);
        longint v, p;
        v = acc;
        p = longint'(1) << sh;
        if (rnd && sh > 0) v = v + p / 2;
        v = (v >= 0) ? v / p : -((-v + p - 1) / p);
        sat = 1'b0;
        if (v > 32767) begin v = 32767; sat = 1'b1; end
        else if (v < -32768) begin v = -32768; sat = 1'b1; end
        case (mode)
            1: if (v < 0) v = 0;
            2: if (v < 0) v = -((-v + 7) / 8);
            3: if (v < 0) v = 0; else if (v > cap) v = cap;
            default: ;
        endcase
        y = int'(v);
    endfunction

    task automatic cyc(input bit en, input int cnt, input int sh, input bit rnd, input int mode,
                       input int cap, input bit clr, input bit use_exp,
                       input logic [63:0] xd, input logic [3:0] xs);
        exp_t it;
        int   y;
        bit   s;
        @(posedge clock);
        #1;
        enable      = en;
        count_sload = 8'(cnt);
        shift_amt   = 5'(sh);
        round_en    = rnd;
        act_mode    = 2'(mode);
        clamp_cap   = 16'(cap);
        sat_clear   = clr;
        for (int c = 0; c < NUM_CH; c++) result[c*ACC_W +: ACC_W] = acc_v[c];
        if (en) drv_cnt++;
        if (en && cnt == TAP) begin
            it.idx = drv_cnt;
            if (use_exp) begin
                it.data = xd;
                it.sat  = xs;
            end else begin
                for (int c = 0; c < NUM_CH; c++) begin
                    model(longint'($signed(acc_v[c])), sh, rnd, mode, cap, y, s);
                    it.data[c*DW +: DW] = y[15:0];
                    it.sat[c]           = s;
                end
            end
            exp_q.push_back(it);
        end
    endtask

    task automatic idle(input bit clr);
        cyc(1'b1, 0, 0, 1'b0, 0, 0, clr, 1'b0, '0, '0);
    endtask

    task automatic set_acc(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        acc_v[0] = a0;
        acc_v[1] = a1;
        acc_v[2] = a2;
        acc_v[3] = a3;
    endtask

    // Monitor: tracks enabled edges, pops on each fresh out_valid, models sticky flags.
    int                   mon_cnt;
    logic [NUM_CH-1:0]    mflags;
    logic [NUM_CH*DW-1:0] last_data;
    bit                   clr_prev, en_prev, ov_prev;

    always @(negedge clock) begin
        exp_t it;
        if (!reset) begin
            mon_cnt   = 0;
            mflags    = '0;
            last_data = '0;
            clr_prev  = 1'b0;
            en_prev   = 1'b0;
            ov_prev   = 1'b0;
        end else begin
            if (en_prev) mon_cnt++;
            mflags = mflags & ~{NUM_CH{clr_prev}};
            if (en_prev && out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_out_valid: got 1 required 0 at %0t", $time);
                end else begin
                    it = exp_q.pop_front();
                    chk("latency_edges", 64'(mon_cnt), 64'(it.idx + 1));
                    last_data = it.data;
                    mflags    = mflags | it.sat;
                end
            end else if (!en_prev) begin
                chk("out_valid_hold", 64'(out_valid), 64'(ov_prev));
            end
            chk("result_relu", 64'(result_relu), 64'(last_data));
            chk("sat_flag", 64'(sat_flag), 64'(mflags));
            ov_prev  = out_valid;
            en_prev  = enable;
            clr_prev = sat_clear;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        count_sload = '0;
        result      = '0;
        shift_amt   = '0;
        round_en    = 1'b0;
        act_mode    = '0;
        clamp_cap   = '0;
        sat_clear   = 1'b0;
        set_acc('0, '0, '0, '0);
        #12;
        chk("reset_result_relu", 64'(result_relu), 64'h0);
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_sat_flag", 64'(sat_flag), 64'h0);
        @(posedge clock);
        #1 reset = 1'b1;

        // ReLU basic, then a non-tap count that must not capture.
        set_acc(32'h0000_5000, -32'sh3000, '0, '0);
        cyc(1, 2, 12, 0, 1, 0, 0, 1, 64'h0000_0000_0000_0005, 4'b0000);
        cyc(1, 1, 12, 0, 1, 0, 0, 0, '0, '0);
        repeat (3) idle(0);

        // Leaky ReLU floors toward -inf.
        set_acc(-32'sh3000, 32'h0000_7000, -32'sh40000, '0);
        cyc(1, 2, 12, 0, 2, 0, 0, 1, 64'h0000_FFF8_0007_FFFF, 4'b0000);

        // Rounding off, then on.
        set_acc(32'h0000_0800, 32'h0000_07FF, -32'sh800, 32'h0000_1800);
        cyc(1, 2, 12, 0, 0, 0, 0, 1, 64'h0001_FFFF_0000_0000, 4'b0000);
        cyc(1, 2, 12, 1, 0, 0, 0, 1, 64'h0002_0000_0000_0001, 4'b0000);
        repeat (3) idle(0);

        // Saturation, then set-wins-over-clear, then clear alone.
        set_acc(32'h4000_0000, -32'sh4000_0000, 32'h07FF_F000, 32'h0800_0000);
        cyc(1, 2, 12, 0, 0, 0, 0, 1, 64'h7FFF_7FFF_8000_7FFF, 4'b1011);
        repeat (3) idle(0);
        set_acc(32'h4000_0000, '0, '0, '0);
        cyc(1, 2, 12, 0, 0, 0, 0, 1, 64'h0000_0000_0000_7FFF, 4'b0001);
        idle(1);
        idle(1);
        repeat (2) idle(0);

        // Clamped ReLU.
        set_acc(32'h0000_A000, 32'h0000_4000, 32'hFFFF_FFFF, 32'h0000_6000);
        cyc(1, 2, 12, 0, 3, 6, 0, 1, 64'h0006_0000_0004_0006, 4'b0000);

        // Stall three cycles right after a capture.
        set_acc(32'h0001_2000, '0, '0, '0);
        cyc(1, 2, 12, 0, 0, 0, 0, 1, 64'h0000_0000_0000_0012, 4'b0000);
        repeat (3) cyc(0, 2, 0, 0, 0, 0, 0, 0, '0, '0);
        repeat (3) idle(0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            bit en;
            int cnt, cap;
            for (int c = 0; c < NUM_CH; c++) begin
                logic [31:0] a;
                a = $urandom;
                if ($urandom_range(0, 1) == 0) a = $signed(a) >>> $urandom_range(0, 24);
                acc_v[c] = a;
            end
            en  = ($urandom_range(0, 9) < 8);
            cnt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : TAP;
            cap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 300));
            cyc(en, cnt, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)), cap, ($urandom_range(0, 15) == 0), 0, '0, '0);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(0);
        repeat (2) idle(0);
        chk("drain_random", 64'(exp_q.size()), 64'h0);

        // Asynchronous reset while a vector is in stage 1.
        set_acc(32'h4000_0000, 32'h0000_3000, '0, '0);
        cyc(1, 2, 12, 0, 0, 0, 0, 1, 64'h0000_0000_0003_7FFF, 4'b0001);
        set_acc(32'h0000_5000, '0, '0, '0);
        cyc(1, 2, 12, 0, 0, 0, 0, 1, 64'h0000_0000_0000_0005, 4'b0000);
        idle(0);
        @(negedge clock);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_rst_result_relu", 64'(result_relu), 64'h0);
        chk("async_rst_out_valid", 64'(out_valid), 64'h0);
        chk("async_rst_sat_flag", 64'(sat_flag), 64'h0);
        exp_q.delete();
        drv_cnt = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (8) idle(0);
        chk("post_reset_queue", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
